mpf_vtp_lookup_rob: RTL

Parametrised tag allocator and response reorder buffer between a VTP pipeline port and the shared VTP translation service. It assigns a dynamically unique `t_mpf_vtp_req_tag` to each 4KB page lookup, forwards the lookup to the service and captures out-of-order service responses together with per-request client metadata. It then returns each response either in request order or in arrival order, depending on the mode. It replaces the fixed 32-entry tracking assumption with a configurable depth and ordering mode.

---
 rtl/mpf_vtp_lookup_rob.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mpf_vtp_lookup_rob.sv
// mpf_vtp_lookup_rob: tag allocator and response reorder buffer for VTP page lookups.
// svc_req = {pageVA, isSpeculative, tag}; svc_rsp/rsp = {tag, pagePA, error, isBigPage, mayCache}.
module mpf_vtp_lookup_rob #(
    parameter int N_ENTRIES = 32,
    parameter bit IN_ORDER  = 1'b1,
    parameter int META_BITS = 8,
    parameter int VA_BITS   = 36,
    parameter int PA_BITS   = 28,
    parameter int TAG_BITS  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_en_i,
    input  logic [VA_BITS-1:0]            req_pageVA_i,
    input  logic                          req_isSpeculative_i,
    input  logic [META_BITS-1:0]          req_meta_i,
    output logic                          req_rdy_o,
    output logic                          svc_req_en_o,
    output logic [VA_BITS+TAG_BITS:0]     svc_req_o,
    input  logic                          svc_rsp_en_i,
    input  logic [TAG_BITS+PA_BITS+2:0]   svc_rsp_i,
    output logic                          rsp_valid_o,
    output logic [TAG_BITS+PA_BITS+2:0]   rsp_o,
    output logic [META_BITS-1:0]          rsp_meta_o,
    input  logic                          rsp_deq_i,
    output logic [$clog2(N_ENTRIES):0]    n_outstanding_o,
    output logic                          err_bad_tag_o
);
    localparam int IW   = $clog2(N_ENTRIES);
    localparam int PL_W = PA_BITS + 3;

    logic [N_ENTRIES-1:0]          busy_q, busy_d, done_q, done_d;
    logic [META_BITS-1:0]          meta_q [N_ENTRIES];
    logic [META_BITS-1:0]          meta_d [N_ENTRIES];
    logic [PL_W-1:0]               pl_q [N_ENTRIES];
    logic [PL_W-1:0]               pl_d [N_ENTRIES];
    logic [IW-1:0]                 head_q, head_d, tail_q, tail_d, sel_q, sel_d, alloc, rsp_idx;
    logic [IW:0]                   cnt_q, cnt_d;
    logic [TAG_BITS-1:0]           rsp_tag;
    logic                          acc, deq, rsp_ok, hold, nvalid;
    logic                          rdy_q, svc_req_en_q, rsp_valid_q, err_q;
    logic [VA_BITS+TAG_BITS:0]     svc_req_q;
    logic [TAG_BITS+PA_BITS+2:0]   rsp_q;
    logic [META_BITS-1:0]          rsp_meta_q;

    always_comb begin
        acc     = req_en_i & rdy_q;
        deq     = rsp_deq_i & rsp_valid_q;
        hold    = rsp_valid_q & ~rsp_deq_i;
        rsp_tag = svc_rsp_i[PL_W +: TAG_BITS];
        rsp_idx = rsp_tag[IW-1:0];
        rsp_ok  = svc_rsp_en_i && (32'(rsp_tag) < N_ENTRIES) && busy_q[rsp_idx] && !done_q[rsp_idx];
        // Allocation looks only at registered busy, so a slot freed this cycle waits one cycle.
        alloc = tail_q;
        if (!IN_ORDER)
            for (int i = N_ENTRIES - 1; i >= 0; i--)
                if (!busy_q[i]) alloc = IW'(i);
        busy_d = busy_q;
        done_d = done_q;
        meta_d = meta_q;
        pl_d   = pl_q;
        if (deq) begin
            busy_d[sel_q] = 1'b0;
            done_d[sel_q] = 1'b0;
        end
        if (acc) begin
            busy_d[alloc] = 1'b1;
            meta_d[alloc] = req_meta_i;
        end
        if (rsp_ok) begin
            done_d[rsp_idx] = 1'b1;
            pl_d[rsp_idx]   = svc_rsp_i[PL_W-1:0];
        end
        head_d = head_q + IW'(deq);
        tail_d = tail_q + IW'(acc);
        cnt_d  = cnt_q + (IW+1)'(acc) - (IW+1)'(deq);
        // Selection uses next-state done so a response can present the cycle after it arrives.
        sel_d = head_d;
        if (!IN_ORDER)
            for (int i = N_ENTRIES - 1; i >= 0; i--)
                if (done_d[i]) sel_d = IW'(i);
        nvalid = done_d[sel_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            rdy_q        <= 1'b0;
            svc_req_en_q <= 1'b0;
            svc_req_q    <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            sel_q        <= '0;
            rsp_q        <= '0;
            rsp_meta_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            rdy_q        <= cnt_d != (IW+1)'(N_ENTRIES);
            svc_req_en_q <= acc;
            if (acc) svc_req_q <= {req_pageVA_i, req_isSpeculative_i, TAG_BITS'(alloc)};
            err_q        <= err_q | (svc_rsp_en_i & ~rsp_ok);
            if (!hold) begin
                rsp_valid_q <= nvalid;
                sel_q       <= sel_d;
                rsp_q       <= nvalid ? {TAG_BITS'(sel_d), pl_d[sel_d]} : '0;
                rsp_meta_q  <= nvalid ? meta_d[sel_d] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        pl_q   <= pl_d;
    end

    assign req_rdy_o       = rdy_q;
    assign svc_req_en_o    = svc_req_en_q;
    assign svc_req_o       = svc_req_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_o           = rsp_q;
    assign rsp_meta_o      = rsp_meta_q;
    assign n_outstanding_o = cnt_q;
    assign err_bad_tag_o   = err_q;
endmodule
